// File: rtl/l1ca_epoch_dump.sv
// l1ca_epoch_dump: snapshots a tracking channel's E/P/L I/Q accumulators on the
// rising edge of its code epoch and queues them for the loop processor.
// Latency: a capture in cycle C becomes visible (out_valid/level) in C+1.
// Backpressure: out_valid/out_ready; a capture that finds the queue full with no
// pop in that cycle is dropped and counted in drop_count (saturating at 255).
//
// Build option: define DUMP_PHASE_EN to store code_phase/lo_phase per entry;
// without it the phase outputs are tied to 0 and the phase inputs are unused.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   en, clear           channel enable and synchronous flush (shared with the channel)
//   epoch               channel epoch level; its rising edge triggers a capture
//   ie..ql              channel accumulators (two's complement, ACC_W bits)
//   code_phase/lo_phase channel NCO phases
//   out_valid/out_ready head handshake; out_* present the head entry
//   out_seq             head epoch sequence number (advances on drops too)
//   out_partial         head is the first capture after reset/clear
//   level               queue occupancy
//   drop_count          captures lost to a full queue, saturating

// dump_fifo: generic first-word-fall-through queue with resettable storage.
// Latency: a push is visible at the head one cycle later; the head is read
// combinationally. Backpressure: a push into a full queue is accepted only
// when a pop happens in the same cycle; push_ok reports acceptance.
module dump_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_ok  = pop & ~empty & ~flush;
  // The slot freed by a same-cycle pop can be refilled immediately.
  assign push_ok = push & ~flush & (~full | pop_ok);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared by reset so the head outputs read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end
endmodule

module l1ca_epoch_dump #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   epoch,
  input  logic [ACC_W-1:0]       ie,
  input  logic [ACC_W-1:0]       qe,
  input  logic [ACC_W-1:0]       ip,
  input  logic [ACC_W-1:0]       qp,
  input  logic [ACC_W-1:0]       il,
  input  logic [ACC_W-1:0]       ql,
  input  logic [31:0]            code_phase,
  input  logic [31:0]            lo_phase,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_ie,
  output logic [ACC_W-1:0]       out_qe,
  output logic [ACC_W-1:0]       out_ip,
  output logic [ACC_W-1:0]       out_qp,
  output logic [ACC_W-1:0]       out_il,
  output logic [ACC_W-1:0]       out_ql,
  output logic [31:0]            out_code_phase,
  output logic [31:0]            out_lo_phase,
  output logic [15:0]            out_seq,
  output logic                   out_partial,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_count
);

  typedef struct packed {
    logic [ACC_W-1:0] ie;
    logic [ACC_W-1:0] qe;
    logic [ACC_W-1:0] ip;
    logic [ACC_W-1:0] qp;
    logic [ACC_W-1:0] il;
    logic [ACC_W-1:0] ql;
`ifdef DUMP_PHASE_EN
    logic [31:0]      code_phase;
    logic [31:0]      lo_phase;
`endif
    logic [15:0]      seq;
    logic             partial;
  } entry_t;

  logic        epoch_d;
  logic        cap;
  logic        pop;
  logic        drop;
  logic        push_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] seq_cnt;
  logic        first_flag;
  entry_t      wr_entry;
  entry_t      head;

  // The channel zeroes its accumulators on the same epoch edge, so the inputs
  // must be sampled in this very cycle.
  assign cap  = en & ~clear & epoch & ~epoch_d;
  assign pop  = out_valid & out_ready & ~clear;
  assign drop = cap & ~push_ok;

  always_comb begin
    wr_entry         = '0;
    wr_entry.ie      = ie;
    wr_entry.qe      = qe;
    wr_entry.ip      = ip;
    wr_entry.qp      = qp;
    wr_entry.il      = il;
    wr_entry.ql      = ql;
`ifdef DUMP_PHASE_EN
    wr_entry.code_phase = code_phase;
    wr_entry.lo_phase   = lo_phase;
`endif
    wr_entry.seq     = seq_cnt;
    wr_entry.partial = first_flag;
  end

  dump_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear),
    .push    (cap),
    .wdata   (wr_entry),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .level   (level)
  );

  // epoch_d follows epoch even through clear, so an epoch already high when
  // clear drops cannot look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) epoch_d <= 1'b0;
    else     epoch_d <= epoch;
  end

  // Sequence advances on every capture, written or dropped, so software sees
  // a gap in out_seq for each lost integration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt    <= '0;
      first_flag <= 1'b1;
      drop_count <= '0;
    end else if (clear) begin
      seq_cnt    <= '0;
      first_flag <= 1'b1;
      drop_count <= '0;
    end else begin
      if (cap) begin
        seq_cnt    <= seq_cnt + 16'd1;
        first_flag <= 1'b0;
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign out_valid   = ~fifo_empty;
  assign out_ie      = head.ie;
  assign out_qe      = head.qe;
  assign out_ip      = head.ip;
  assign out_qp      = head.qp;
  assign out_il      = head.il;
  assign out_ql      = head.ql;
  assign out_seq     = head.seq;
  assign out_partial = head.partial;

`ifdef DUMP_PHASE_EN
  assign out_code_phase = head.code_phase;
  assign out_lo_phase   = head.lo_phase;
`else
  logic unused_phase;
  assign unused_phase   = ^{code_phase, lo_phase, fifo_full};
  assign out_code_phase = 32'h0;
  assign out_lo_phase   = 32'h0;
`endif

`ifdef DUMP_PHASE_EN
  logic unused_full;
  assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_l1ca_epoch_dump.sv
module tb_l1ca_epoch_dump;
  localparam int DEPTH = 4;
  localparam int ACC_W = 16;

  logic        clk = 1'b0;
  logic        rst, en, clear, epoch, out_ready;
  logic [15:0] ie, qe, ip, qp, il, ql;
  logic [31:0] code_phase, lo_phase;
  logic        out_valid, out_partial;
  logic [15:0] out_ie, out_qe, out_ip, out_qp, out_il, out_ql, out_seq;
  logic [31:0] out_code_phase, out_lo_phase;
  logic [2:0]  level;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  l1ca_epoch_dump #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .epoch(epoch),
    .ie(ie), .qe(qe), .ip(ip), .qp(qp), .il(il), .ql(ql),
    .code_phase(code_phase), .lo_phase(lo_phase),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ie(out_ie), .out_qe(out_qe), .out_ip(out_ip), .out_qp(out_qp),
    .out_il(out_il), .out_ql(out_ql),
    .out_code_phase(out_code_phase), .out_lo_phase(out_lo_phase),
    .out_seq(out_seq), .out_partial(out_partial),
    .level(level), .drop_count(drop_count)
  );

  // Reference model: a queue of snapshots plus the few counters software sees.
  typedef struct {
    logic [15:0] ie, qe, ip, qp, il, ql;
    logic [31:0] cp, lp;
    logic [15:0] seq;
    logic        partial;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_seq;
  int          m_drop;
  bit          m_first;
  bit          m_prev;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0; m_drop = 0; m_first = 1; m_prev = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   cap, full_b, popping;
    ent_t e, dummy;
    if (clear) begin
      q.delete();
      m_seq = 0; m_drop = 0; m_first = 1;
    end else begin
      cap     = en && epoch && !m_prev;
      full_b  = (q.size() == DEPTH);
      popping = (q.size() != 0) && out_ready;
      if (popping) dummy = q.pop_front();
      if (cap) begin
        if (!full_b || popping) begin
          e.ie = ie; e.qe = qe; e.ip = ip; e.qp = qp; e.il = il; e.ql = ql;
`ifdef DUMP_PHASE_EN
          e.cp = code_phase; e.lp = lo_phase;
`else
          e.cp = 32'h0; e.lp = 32'h0;
`endif
          e.seq = m_seq; e.partial = m_first;
          q.push_back(e);
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_seq   = m_seq + 16'd1;
        m_first = 0;
      end
    end
    m_prev = epoch;
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("drop_count", drop_count, m_drop);
    if (q.size() != 0) begin
      chk("out_ie", out_ie, q[0].ie);
      chk("out_qe", out_qe, q[0].qe);
      chk("out_ip", out_ip, q[0].ip);
      chk("out_qp", out_qp, q[0].qp);
      chk("out_il", out_il, q[0].il);
      chk("out_ql", out_ql, q[0].ql);
      chk("out_code_phase", out_code_phase, q[0].cp);
      chk("out_lo_phase", out_lo_phase, q[0].lp);
      chk("out_seq", out_seq, q[0].seq);
      chk("out_partial", out_partial, q[0].partial);
    end
  endtask

  task automatic rand_data();
    ie = 16'($urandom); qe = 16'($urandom); ip = 16'($urandom);
    qp = 16'($urandom); il = 16'($urandom); ql = 16'($urandom);
    code_phase = $urandom; lo_phase = $urandom;
  endtask

  // One clock: model update, edge, then compare 1 time unit after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic edge_pulse();
    rand_data(); epoch = 1'b1; step();
    rand_data(); epoch = 1'b0; step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; epoch = 1'b0; out_ready = 1'b0;
    ie = '0; qe = '0; ip = '0; qp = '0; il = '0; ql = '0;
    code_phase = '0; lo_phase = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ip", out_ip, 0);
    chk("rst_seq", out_seq, 0);
    chk("rst_partial", out_partial, 0);
    chk("rst_code_phase", out_code_phase, 0);
    rst = 1'b0;

    // Single capture: epoch rises in cycle 10.
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin rand_data(); step(); end
    rand_data(); ip = 16'h0123; qp = 16'hFFF0; code_phase = 32'h8000_0000;
    epoch = 1'b1; step();
    chk("single_valid", out_valid, 1'b1);
    chk("single_ip", out_ip, 16'h0123);
    chk("single_qp", out_qp, 16'hFFF0);
    chk("single_seq", out_seq, 0);
    chk("single_partial", out_partial, 1'b1);
    chk("single_level", level, 1);
`ifdef DUMP_PHASE_EN
    chk("single_code_phase", out_code_phase, 32'h8000_0000);
`else
    chk("single_code_phase", out_code_phase, 32'h0);
`endif
    epoch = 1'b0; step();

    // Sequence and partial flag with a always-ready consumer.
    do_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_data(); epoch = 1'b1; step();
      chk("seq_seq", out_seq, k);
      chk("seq_partial", out_partial, k == 0);
      rand_data(); epoch = 1'b0; step();
    end
    chk("seq_level_empty", level, 0);

    // Overflow: six edges into a depth-4 queue with no consumer.
    do_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) edge_pulse();
    chk("ovf_level", level, 4);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_head_seq", out_seq, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("ovf_drained", out_valid, 1'b0);
    out_ready = 1'b0;
    rand_data(); epoch = 1'b1; step();
    chk("ovf_next_seq", out_seq, 6);
    epoch = 1'b0; step();

    // Full queue with a capture and a pop in the same cycle.
    for (int k = 0; k < 3; k++) edge_pulse();
    chk("fullpop_pre_level", level, 4);
    out_ready = 1'b1; rand_data(); epoch = 1'b1; step();
    chk("fullpop_level", level, 4);
    chk("fullpop_drop", drop_count, 2);
    out_ready = 1'b0; epoch = 1'b0; step();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Clear while epoch is high: no capture until a fresh rising edge.
    do_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) edge_pulse();
    rand_data(); epoch = 1'b1; step();
    chk("clr_pre_level", level, 3);
    clear = 1'b1; step();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin rand_data(); step(); end
    chk("clr_level", level, 0);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_drop", drop_count, 0);
    epoch = 1'b0; step();
    rand_data(); epoch = 1'b1; step();
    chk("clr_next_seq", out_seq, 0);
    chk("clr_next_partial", out_partial, 1'b1);
    epoch = 1'b0; step();

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      rand_data();
      en        = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) epoch = ~epoch;
      step();
    end
    clear = 1'b0;

    // Reset while entries are queued empties the queue immediately.
    do_clear();
    out_ready = 1'b0; en = 1'b1; epoch = 1'b0;
    for (int k = 0; k < 3; k++) edge_pulse();
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_level", level, 0);
    chk("arst_ip", out_ip, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) edge_pulse();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
